// File: rtl/ucode_pkg.sv
// Microcode word formats, next-state selector encoding and branch helper for useq_ctrl.
// Latency: none, types and a pure function only.
// Backpressure: not applicable.
package ucode_pkg;

  localparam int STATE_W = 8;
  localparam int CTRL_W  = 32;
  localparam int OPC_W   = 14;
  localparam int FLAG_W  = 8;

  typedef enum logic [1:0] {
    NSEL_SEQ    = 2'd0,
    NSEL_OPC    = 2'd1,
    NSEL_BRANCH = 2'd2,
    NSEL_RET    = 2'd3
  } nsel_t;

  typedef struct packed {
    logic [CTRL_W-1:0]  ctrl;
    logic [OPC_W-1:0]   opc;
    logic               last;
    logic               op_sel;
    nsel_t              nsel;
    logic               call;
    logic [STATE_W-1:0] next;
    logic [STATE_W-1:0] ret;
  } uword_t;

  typedef struct packed {
    logic [OPC_W-1:0]   ctrl;
    logic               polarity;
    logic [2:0]         cond_sel;
    logic [FLAG_W-1:0]  flags;
    logic [STATE_W-1:0] next;
  } opword_t;

  // polarity=1 branches on a set flag, polarity=0 on a clear flag
  function automatic logic branch_taken(input logic [7:0] p, input logic [2:0] sel,
                                        input logic polarity);
    return p[sel] ^ ~polarity;
  endfunction

endpackage

// File: rtl/useq_stack.sv
// Micro-call return LIFO with full/empty flags; overflowing pushes and underflowing pops are dropped.
// Latency: push/pop take effect on the next clock; top_dat is combinational from the current top.
// Backpressure: en=0 freezes the stack (whole-sequencer stall).
module useq_stack #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_dat,
  output logic [W-1:0] top_dat,
  output logic         full,
  output logic         empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] wr_idx;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign top_idx = IDX_W'(cnt - 1'b1);
  assign wr_idx  = IDX_W'(cnt);
  assign top_dat = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en) begin
      if (push && !full) begin
        mem[wr_idx] <= push_dat;
        cnt         <= cnt + 1'b1;
      end else if (pop && !empty) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/useq_ctrl.sv
// Microcode sequencer: micro-PC, opcode latch, branch, call/return stack; UCODE_IRQ_EN adds interrupt entry.
// Latency: upc registered from the current uword; controls registered one cycle behind upc.
// Backpressure: ready=0 holds every register and suppresses irq_ack.
module useq_ctrl
  import ucode_pkg::*;
#(
  parameter int STATE_W      = ucode_pkg::STATE_W,
  parameter int CTRL_W       = ucode_pkg::CTRL_W,
  parameter int OPC_W        = ucode_pkg::OPC_W,
  parameter int FLAG_W       = ucode_pkg::FLAG_W,
  parameter int STACK_DEPTH  = 2,
  parameter int RESET_STATE  = 0,
  parameter int TAKEN_STATE  = 63,
  parameter int NTAKEN_STATE = 0,
  parameter int IRQ_STATE    = 1,
  parameter int I_BIT        = 2
) (
  input  logic                    clk,
  input  logic                    reset_b,
  input  logic                    ready,
  input  logic [7:0]              data_in,
  input  logic [7:0]              p,
  output logic [STATE_W-1:0]      upc,
  input  uword_t                  uword,
  output logic [7:0]              opcode,
  input  opword_t                 opword,
  output logic [FLAG_W-1:0]       op_flags,
  output logic [CTRL_W+OPC_W-1:0] controls,
  input  logic                    irq,
  output logic                    irq_ack,
  output logic                    ustack_err
);

  logic               first;
  logic               irq_req;
  logic               irq_take;
  logic               ret_sel;
  logic               push_req;
  logic               pop_req;
  logic               err_set;
  logic               first_nxt;
  logic [STATE_W-1:0] upc_nxt;
  logic [STATE_W-1:0] stk_top;
  logic               stk_full;
  logic               stk_empty;

  assign op_flags = opword.flags;
  assign irq_req  = uword.last & irq & ~p[I_BIT];

  useq_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (STATE_W)
  ) u_stack (
    .clk      (clk),
    .rst_n    (reset_b),
    .en       (ready),
    .push     (push_req),
    .pop      (pop_req),
    .push_dat (uword.ret),
    .top_dat  (stk_top),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  always_comb begin
    irq_take  = 1'b0;
`ifdef UCODE_IRQ_EN
    irq_take  = irq_req;
`else
    // interrupts are not part of this build; irq_req is folded away
    irq_take  = 1'b0 & irq_req;
`endif
    // interrupt entry overrides nsel, so a RET under irq neither pops nor blocks the push
    ret_sel   = (uword.nsel == NSEL_RET) && !irq_take;
    pop_req   = ret_sel;
    push_req  = uword.call && !ret_sel;
    err_set   = (push_req && stk_full) || (pop_req && stk_empty);
    first_nxt = uword.last && !irq_take;

    upc_nxt = uword.next;
    case (uword.nsel)
      NSEL_SEQ:    upc_nxt = uword.next;
      NSEL_OPC:    upc_nxt = opword.next;
      NSEL_BRANCH: upc_nxt = branch_taken(p, opword.cond_sel, opword.polarity)
                             ? STATE_W'(TAKEN_STATE) : STATE_W'(NTAKEN_STATE);
      NSEL_RET:    upc_nxt = stk_empty ? STATE_W'(RESET_STATE) : stk_top;
      default:     upc_nxt = uword.next;
    endcase
    if (irq_take) upc_nxt = STATE_W'(IRQ_STATE);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      upc        <= STATE_W'(RESET_STATE);
      opcode     <= '0;
      first      <= 1'b0;
      controls   <= '0;
      ustack_err <= 1'b0;
    end else if (ready) begin
      upc      <= upc_nxt;
      first    <= first_nxt;
      controls <= {uword.ctrl, uword.op_sel ? opword.ctrl : uword.opc};
      if (first)   opcode     <= data_in;
      if (err_set) ustack_err <= 1'b1;
    end
  end

`ifdef UCODE_IRQ_EN
  logic irq_ack_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) irq_ack_q <= 1'b0;
    else          irq_ack_q <= ready & irq_take;
  end

  assign irq_ack = irq_ack_q;
`else
  assign irq_ack = 1'b0;
`endif

endmodule

// File: tb/tb_useq_ctrl.sv
// Directed-vector bench for useq_ctrl: ROM words are driven by the bench each cycle.
module tb_useq_ctrl;
  import ucode_pkg::*;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        ready;
  logic [7:0]  data_in;
  logic [7:0]  p;
  logic [7:0]  upc;
  uword_t      uword;
  logic [7:0]  opcode;
  opword_t     opword;
  logic [7:0]  op_flags;
  logic [45:0] controls;
  logic        irq;
  logic        irq_ack;
  logic        ustack_err;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  useq_ctrl dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .ready      (ready),
    .data_in    (data_in),
    .p          (p),
    .upc        (upc),
    .uword      (uword),
    .opcode     (opcode),
    .opword     (opword),
    .op_flags   (op_flags),
    .controls   (controls),
    .irq        (irq),
    .irq_ack    (irq_ack),
    .ustack_err (ustack_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_uw(input nsel_t nsel, input logic [7:0] nxt, input logic last,
                        input logic call, input logic [7:0] ret);
    uword      = '0;
    uword.nsel = nsel;
    uword.next = nxt;
    uword.last = last;
    uword.call = call;
    uword.ret  = ret;
  endtask

  task automatic test_reset();
    reset_b = 1'b0; ready = 1'b1; data_in = '0; p = '0; irq = 1'b0;
    uword = '0; opword = '0;
    #12;
    total++; if (upc !== 8'd0)      $display("FAIL rst_upc: got %0d want 0", upc); else passed++;
    total++; if (opcode !== 8'd0)   $display("FAIL rst_opcode: got %h want 00", opcode); else passed++;
    total++; if (controls !== '0)   $display("FAIL rst_controls: got %h want 0", controls); else passed++;
    total++; if (ustack_err !== 0)  $display("FAIL rst_err: got %b want 0", ustack_err); else passed++;
    total++; if (irq_ack !== 0)     $display("FAIL rst_irq_ack: got %b want 0", irq_ack); else passed++;
    reset_b = 1'b1;
    // pop on an empty stack: falls back to RESET_STATE and flags the error
    set_uw(NSEL_RET, 8'd0, 1'b0, 1'b0, 8'd0);
    tick();
    total++; if (upc !== 8'd0)      $display("FAIL underflow_upc: got %0d want 0", upc); else passed++;
    total++; if (ustack_err !== 1)  $display("FAIL underflow_err: got %b want 1", ustack_err); else passed++;
    set_uw(NSEL_SEQ, 8'd5, 1'b0, 1'b0, 8'd0);
    uword.ctrl = 32'hDEADBEEF; uword.opc = 14'h0123;
    tick();
    total++; if (upc !== 8'd5) $display("FAIL seq_upc: got %0d want 5", upc); else passed++;
    total++; if (controls !== {32'hDEADBEEF, 14'h0123})
      $display("FAIL seq_controls: got %h want %h", controls, {32'hDEADBEEF, 14'h0123}); else passed++;
    #2 reset_b = 1'b0;
    #1;
    total++; if (upc !== 8'd0)     $display("FAIL midrst_upc: got %0d want 0", upc); else passed++;
    total++; if (controls !== '0)  $display("FAIL midrst_controls: got %h want 0", controls); else passed++;
    total++; if (ustack_err !== 0) $display("FAIL midrst_err: got %b want 0", ustack_err); else passed++;
    reset_b = 1'b1;
  endtask

  task automatic test_dispatch();
    set_uw(NSEL_SEQ, 8'd2, 1'b1, 1'b0, 8'd0);
    tick();
    total++; if (upc !== 8'd2) $display("FAIL disp_pre_upc: got %0d want 2", upc); else passed++;
    set_uw(NSEL_OPC, 8'd0, 1'b0, 1'b0, 8'd0);
    uword.op_sel = 1'b1; uword.ctrl = 32'h11110000; uword.opc = 14'h3FFF;
    opword = '0; opword.next = 8'd6; opword.flags = 8'h5A; opword.ctrl = 14'h02AB;
    data_in = 8'hA9;
    #1;
    total++; if (op_flags !== 8'h5A) $display("FAIL op_flags: got %h want 5a", op_flags); else passed++;
    tick();
    total++; if (opcode !== 8'hA9) $display("FAIL disp_opcode: got %h want a9", opcode); else passed++;
    total++; if (upc !== 8'd6)     $display("FAIL disp_upc: got %0d want 6", upc); else passed++;
    total++; if (controls !== {32'h11110000, 14'h02AB})
      $display("FAIL disp_controls: got %h want %h", controls, {32'h11110000, 14'h02AB}); else passed++;
    set_uw(NSEL_SEQ, 8'd7, 1'b0, 1'b0, 8'd0);
    data_in = 8'h00;
    tick();
    total++; if (opcode !== 8'hA9) $display("FAIL disp_hold_opcode: got %h want a9", opcode); else passed++;
    total++; if (upc !== 8'd7)     $display("FAIL disp_next_upc: got %0d want 7", upc); else passed++;
  endtask

  task automatic test_branch();
    set_uw(NSEL_BRANCH, 8'd0, 1'b0, 1'b0, 8'd0);
    opword = '0; opword.cond_sel = 3'd1; opword.polarity = 1'b1;
    p = 8'h02; tick();
    total++; if (upc !== 8'd63) $display("FAIL br_set_taken: got %0d want 63", upc); else passed++;
    p = 8'h00; tick();
    total++; if (upc !== 8'd0)  $display("FAIL br_clr_ntaken: got %0d want 0", upc); else passed++;
    opword.polarity = 1'b0;
    tick();
    total++; if (upc !== 8'd63) $display("FAIL br_neg_taken: got %0d want 63", upc); else passed++;
    p = 8'hFD; tick();
    total++; if (upc !== 8'd63) $display("FAIL br_neg_other_bits: got %0d want 63", upc); else passed++;
    p = 8'h02; tick();
    total++; if (upc !== 8'd0)  $display("FAIL br_neg_ntaken: got %0d want 0", upc); else passed++;
    p = 8'h00; opword = '0;
  endtask

  task automatic test_stall();
    set_uw(NSEL_SEQ, 8'd10, 1'b1, 1'b0, 8'd0);
    uword.ctrl = 32'hC1C1C1C1; uword.opc = 14'h00C1;
    tick();
    total++; if (upc !== 8'd10) $display("FAIL stall_pre_upc: got %0d want 10", upc); else passed++;
    ready = 1'b0; data_in = 8'h33;
    set_uw(NSEL_SEQ, 8'd20, 1'b0, 1'b0, 8'd0);
    uword.ctrl = 32'hC2C2C2C2; uword.opc = 14'h00C2;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (upc !== 8'd10)    $display("FAIL stall_upc[%0d]: got %0d want 10", i, upc); else passed++;
      total++; if (opcode !== 8'hA9) $display("FAIL stall_opcode[%0d]: got %h want a9", i, opcode); else passed++;
      total++; if (controls !== {32'hC1C1C1C1, 14'h00C1})
        $display("FAIL stall_controls[%0d]: got %h", i, controls); else passed++;
    end
    ready = 1'b1; data_in = 8'h77;
    tick();
    total++; if (upc !== 8'd20)    $display("FAIL resume_upc: got %0d want 20", upc); else passed++;
    total++; if (opcode !== 8'h77) $display("FAIL resume_opcode: got %h want 77", opcode); else passed++;
    total++; if (controls !== {32'hC2C2C2C2, 14'h00C2})
      $display("FAIL resume_controls: got %h", controls); else passed++;
    data_in = 8'h00;
  endtask

  task automatic test_stack();
    set_uw(NSEL_SEQ, 8'd40, 1'b0, 1'b1, 8'd30); tick();
    total++; if (upc !== 8'd40)    $display("FAIL call1_upc: got %0d want 40", upc); else passed++;
    set_uw(NSEL_SEQ, 8'd41, 1'b0, 1'b1, 8'd31); tick();
    total++; if (upc !== 8'd41)    $display("FAIL call2_upc: got %0d want 41", upc); else passed++;
    total++; if (ustack_err !== 0) $display("FAIL call2_err: got %b want 0", ustack_err); else passed++;
    set_uw(NSEL_SEQ, 8'd42, 1'b0, 1'b1, 8'd32); tick();
    total++; if (upc !== 8'd42)    $display("FAIL call3_upc: got %0d want 42", upc); else passed++;
    total++; if (ustack_err !== 1) $display("FAIL overflow_err: got %b want 1", ustack_err); else passed++;
    set_uw(NSEL_RET, 8'd0, 1'b0, 1'b0, 8'd0); tick();
    total++; if (upc !== 8'd31)    $display("FAIL ret1_upc: got %0d want 31", upc); else passed++;
    tick();
    total++; if (upc !== 8'd30)    $display("FAIL ret2_upc: got %0d want 30", upc); else passed++;
    set_uw(NSEL_RET, 8'd99, 1'b0, 1'b0, 8'd0); tick();
    total++; if (upc !== 8'd0)     $display("FAIL ret3_upc: got %0d want 0", upc); else passed++;
    total++; if (ustack_err !== 1) $display("FAIL err_sticky: got %b want 1", ustack_err); else passed++;
    // call together with RET: the return wins and the push is discarded
    set_uw(NSEL_SEQ, 8'd7, 1'b0, 1'b1, 8'd30); tick();
    set_uw(NSEL_RET, 8'd0, 1'b0, 1'b1, 8'd50); tick();
    total++; if (upc !== 8'd30)    $display("FAIL callret_upc: got %0d want 30", upc); else passed++;
    set_uw(NSEL_RET, 8'd0, 1'b0, 1'b0, 8'd0); tick();
    total++; if (upc !== 8'd0)     $display("FAIL callret_nopush: got %0d want 0", upc); else passed++;
  endtask

  task automatic test_irq();
    p = 8'h00; irq = 1'b1;
    set_uw(NSEL_SEQ, 8'd3, 1'b1, 1'b0, 8'd0);
    tick();
`ifdef UCODE_IRQ_EN
    total++; if (upc !== 8'd1)  $display("FAIL irq_upc: got %0d want 1", upc); else passed++;
    total++; if (irq_ack !== 1) $display("FAIL irq_ack_pulse: got %b want 1", irq_ack); else passed++;
    irq = 1'b0; data_in = 8'h55;
    set_uw(NSEL_SEQ, 8'd9, 1'b0, 1'b0, 8'd0);
    tick();
    total++; if (upc !== 8'd9)     $display("FAIL irq_next_upc: got %0d want 9", upc); else passed++;
    total++; if (irq_ack !== 0)    $display("FAIL irq_ack_end: got %b want 0", irq_ack); else passed++;
    total++; if (opcode !== 8'h77) $display("FAIL irq_opcode_held: got %h want 77", opcode); else passed++;
    p = 8'h04; irq = 1'b1;
    set_uw(NSEL_SEQ, 8'd3, 1'b1, 1'b0, 8'd0);
    tick();
`endif
    total++; if (upc !== 8'd3)  $display("FAIL irq_masked_upc: got %0d want 3", upc); else passed++;
    total++; if (irq_ack !== 0) $display("FAIL irq_masked_ack: got %b want 0", irq_ack); else passed++;
    irq = 1'b0; data_in = 8'h66;
    set_uw(NSEL_SEQ, 8'd4, 1'b0, 1'b0, 8'd0);
    tick();
    total++; if (opcode !== 8'h66) $display("FAIL fetch_opcode: got %h want 66", opcode); else passed++;
    total++; if (upc !== 8'd4)     $display("FAIL fetch_upc: got %0d want 4", upc); else passed++;
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_branch();
    test_stall();
    test_stack();
    test_irq();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
